// File: rtl/uart_alu_ctrl.sv
// Byte-framed ALU front end: collects operand A, operand B and an opcode from a
// UART receiver, runs one ALU cycle and hands the result to the UART transmitter.
module uart_alu_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [DATA_BITS-1:0] i_rx_data,
  output logic [DATA_BITS-1:0] o_alu_a,
  output logic [DATA_BITS-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_op,
  input  logic [DATA_BITS-1:0] i_alu_result,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [DATA_BITS-1:0] a_q, b_q, tx_data_q;
  logic [OP_BITS-1:0]   op_q;
  logic                 tx_start_q, err_q;

  logic [OP_BITS-1:0]   rx_op;
  logic                 op_ok;
  logic                 tmo;

  assign rx_op = i_rx_data[OP_BITS-1:0];
  assign tmo   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    op_ok = 1'b0;
    case (rx_op)
      OP_BITS'(6'b100000), OP_BITS'(6'b100010), OP_BITS'(6'b100100),
      OP_BITS'(6'b100101), OP_BITS'(6'b100110), OP_BITS'(6'b100111),
      OP_BITS'(6'b000011), OP_BITS'(6'b000010): op_ok = 1'b1;
      default:                                  op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (i_rx_done) begin
            a_q     <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          // a byte landing on the expiry cycle wins over the timeout
          if (i_rx_done) begin
            b_q     <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_OP;
          end else if (tmo) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT_A;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            cnt_q <= '0;
            if (op_ok) begin
              op_q    <= rx_op;
              state_q <= EXEC;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_A;
            end
          end else if (tmo) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= WAIT_A;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXEC: begin
          err_q     <= i_rx_done;
          tx_data_q <= i_alu_result;
          state_q   <= SEND;
        end
        SEND: begin
          err_q      <= i_rx_done;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TX;
        end
        WAIT_TX: begin
          err_q <= i_rx_done;
          if (i_tx_done) state_q <= WAIT_A;
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != WAIT_A);

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, operand/result/byte width.
REQ-002 SHALL have parameter OP_BITS, default 6, ALU opcode width (low OP_BITS of the opcode byte).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, max i_clk cycles allowed between bytes of one frame.
REQ-004 SHALL have port i_clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_rx_done  input  1  one-cycle pulse from UART receiver, byte valid.
REQ-007 SHALL have port i_rx_data  input  DATA_BITS  received byte, sampled only when i_rx_done=1.
REQ-008 SHALL have port o_alu_a  output  DATA_BITS  registered operand A to ALU.
REQ-009 SHALL have port o_alu_b  output  DATA_BITS  registered operand B to ALU.
REQ-010 SHALL have port o_alu_op  output  OP_BITS  registered opcode to ALU.
REQ-011 SHALL have port i_alu_result  input  DATA_BITS  combinational ALU result.
REQ-012 SHALL have port o_tx_start  output  1  one-cycle pulse requesting UART transmit.
REQ-013 SHALL have port o_tx_data  output  DATA_BITS  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-014 SHALL have port i_tx_done  input  1  one-cycle pulse, transmitter finished.
REQ-015 SHALL have port o_busy  output  1  high in any state other than WAIT_A.
REQ-016 SHALL have port o_err  output  1  one-cycle pulse on frame error (timeout, bad opcode, overrun).

Function
REQ-017 SHALL implement states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-018 WAIT_A: on i_rx_done, SHALL latch i_rx_data into o_alu_a and go to WAIT_B.
REQ-019 WAIT_B: on i_rx_done, SHALL latch into o_alu_b and go to WAIT_OP.
REQ-020 WAIT_OP: on i_rx_done with valid opcode, SHALL latch i_rx_data[OP_BITS-1:0] into o_alu_op and go to EXEC.
REQ-021 Valid opcodes SHALL be exactly 6'b100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL; upper byte bits SHALL be ignored.
REQ-022 Invalid opcode SHALL pulse o_err one cycle, leave o_alu_op unchanged, return to WAIT_A.
REQ-023 EXEC SHALL last exactly one cycle, latch i_alu_result into o_tx_data, go to SEND.
REQ-024 SEND SHALL assert o_tx_start for exactly one cycle and go to WAIT_TX; o_tx_start SHALL rise 3 cycles after the i_rx_done carrying the opcode.
REQ-025 WAIT_TX: on i_tx_done SHALL go to WAIT_A; i_tx_done in any other state SHALL be ignored.
REQ-026 A timeout counter SHALL clear on every accepted byte and on entry to WAIT_B/WAIT_OP, increment each cycle in WAIT_B and WAIT_OP only.
REQ-027 Counter reaching TIMEOUT_CYCLES-1 without i_rx_done SHALL pulse o_err and return to WAIT_A; counter SHALL saturate-free wrap to 0 on that event.
REQ-028 i_rx_done in the same cycle as timeout expiry SHALL be accepted as a byte, no error.
REQ-029 i_rx_done during EXEC, SEND or WAIT_TX SHALL be dropped and pulse o_err; sequence SHALL continue unaffected.
REQ-030 o_alu_a/o_alu_b/o_alu_op SHALL hold last latched values until overwritten; partial frames aborted by error SHALL keep already-latched fields.
REQ-031 o_err and o_tx_start SHALL be registered, glitch-free.

Reset
REQ-032 Asserting i_reset SHALL immediately force state WAIT_A, timeout counter 0, all outputs 0, regardless of clock or in-progress frame.
REQ-033 After deassertion, first accepted byte SHALL be treated as operand A.

Verification
REQ-034 Bytes 0x05,0x03,0x20 (ADD), ALU returns 0x08 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_data=0x08, o_tx_start one pulse 3 cycles after third i_rx_done.
REQ-035 Bytes 0x0F,0x01,0x3F -> o_err one pulse, no o_tx_start, o_busy=0 next cycle.
REQ-036 TIMEOUT_CYCLES=16, byte 0xAA then silence -> o_err pulse 16 cycles after entry to WAIT_B, state WAIT_A.
REQ-037 i_rx_done pulsed in WAIT_TX -> o_err pulse, o_tx_data unchanged, i_tx_done still returns to WAIT_A.
REQ-038 i_reset asserted mid-WAIT_OP between clock edges -> outputs 0 asynchronously; next frame 0x02,0x02,0x22 (SUB) -> o_tx_data=ALU result of 0x02-0x02=0x00.
